// File: rtl/register_file_writeback.sv
// Register file with write bypass, a hardwired-zero register 31 and a busy
// scoreboard that tracks registers reserved by in-flight producers.
module register_file_writeback #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [31:0]           wr_onehot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [4:0]            rd_sel_a,
    input  logic [4:0]            rd_sel_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  rsv_valid,
    input  logic [4:0]            rsv_sel,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [5:0]            busy_count,
    output logic                  onehot_err
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [31:0]           busy;
    logic [31:0]           busy_next;
    logic [31:0]           rsv_mask;
    logic [4:0]            wr_idx;
    logic [5:0]            count_next;
    logic                  single_hot;
    logic                  wr_valid;
    logic                  wr_store;

    assign single_hot = (wr_onehot != '0) && ((wr_onehot & (wr_onehot - 32'd1)) == '0);
    assign wr_valid   = wr_en && single_hot;
    // A valid write to register 31 is accepted (no error) but never stored.
    assign wr_store   = wr_valid && !wr_onehot[31];

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        wr_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (wr_onehot[i]) wr_idx = 5'(i);
        end
    end

    always_comb begin
        rsv_mask = '0;
        if (rsv_valid && rsv_sel != ZERO_REG) rsv_mask[rsv_sel] = 1'b1;
    end

    // Clear by the write first, then set by the reservation: the newer producer wins.
    assign busy_next = (busy & ~(wr_valid ? wr_onehot : 32'd0)) | rsv_mask;

    always_comb begin
        count_next = '0;
        for (int i = 0; i < 32; i++) begin
            count_next = count_next + 6'(busy_next[i]);
        end
    end

    assign rd_data_a = (rd_sel_a == ZERO_REG)               ? '0      :
                       (wr_store && wr_idx == rd_sel_a)     ? wr_data :
                                                              regs[rd_sel_a];
    assign rd_data_b = (rd_sel_b == ZERO_REG)               ? '0      :
                       (wr_store && wr_idx == rd_sel_b)     ? wr_data :
                                                              regs[rd_sel_b];

    assign busy_a = busy[rd_sel_a] && !(wr_valid && wr_onehot[rd_sel_a]);
    assign busy_b = busy[rd_sel_b] && !(wr_valid && wr_onehot[rd_sel_b]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the whole array is reset because reads of never-written
            // registers must return 0, not X.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
            onehot_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (wr_store) regs[wr_idx] <= wr_data;
            busy       <= busy_next;
            busy_count <= count_next;
            if (wr_en && !single_hot) onehot_err <= 1'b1;
        end
    end

endmodule
